// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: byte-addressable little-endian data memory with
// aligned load/store, load extension, LUI select and registered writeback controls.
module mem_wb_stage #(
    parameter int BITS_SIZE = 32,
    parameter int MEM_DEPTH = 256,
    parameter int REG_ADDR  = 5,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [BITS_SIZE-1:0] i_alu_result,
    input  logic [BITS_SIZE-1:0] i_write_data,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_width,
    input  logic                 i_unsigned,
    input  logic                 i_lui,
    input  logic [15:0]          i_imm,
    input  logic                 i_mem_to_reg,
    input  logic                 i_reg_write,
    input  logic                 i_halt,
    input  logic [REG_ADDR-1:0]  i_rd,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [AW-1:0]        i_dbg_addr,
    output logic [BITS_SIZE-1:0] o_dbg_data,
    output logic                 o_mem_to_reg,
    output logic                 o_reg_write,
    output logic                 o_halt,
    output logic                 o_misaligned,
    output logic [BITS_SIZE-1:0] o_data_to_reg,
    output logic [BITS_SIZE-1:0] o_alu,
    output logic [REG_ADDR-1:0]  o_rd
);

    logic [BITS_SIZE-1:0] mem_q [MEM_DEPTH];

    logic [AW-1:0]        widx;
    logic [4:0]           lane_sh;
    logic [BITS_SIZE-1:0] rd_word;
    logic [BITS_SIZE-1:0] rd_shifted;
    logic [BITS_SIZE-1:0] load_val;
    logic [BITS_SIZE-1:0] wr_mask;
    logic [BITS_SIZE-1:0] mem_word_d;
    logic                 misalign_cond;
    logic                 mem_we;

    logic                 mem_to_reg_d, mem_to_reg_q;
    logic                 reg_write_d, reg_write_q;
    logic                 halt_d, halt_q;
    logic                 misaligned_d, misaligned_q;
    logic [BITS_SIZE-1:0] data_to_reg_d, data_to_reg_q;
    logic [BITS_SIZE-1:0] alu_d, alu_q;
    logic [REG_ADDR-1:0]  rd_d, rd_q;

    // Upper address bits are deliberately ignored (memory aliases).
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_alu_result[BITS_SIZE-1:AW+2];

    assign widx       = i_alu_result[AW+1:2];
    assign lane_sh    = {i_alu_result[1:0], 3'b000};
    assign rd_word    = mem_q[widx];
    assign rd_shifted = rd_word >> lane_sh;
    assign o_dbg_data = mem_q[i_dbg_addr];

    always_comb begin
        misalign_cond = 1'b0;
        load_val      = rd_word;
        wr_mask       = '1;
        case (i_width)
            2'b00: begin
                load_val = i_unsigned ? {{(BITS_SIZE-8){1'b0}}, rd_shifted[7:0]}
                                      : {{(BITS_SIZE-8){rd_shifted[7]}}, rd_shifted[7:0]};
                wr_mask  = BITS_SIZE'(8'hFF) << lane_sh;
            end
            2'b01: begin
                misalign_cond = i_alu_result[0];
                load_val = i_unsigned ? {{(BITS_SIZE-16){1'b0}}, rd_shifted[15:0]}
                                      : {{(BITS_SIZE-16){rd_shifted[15]}}, rd_shifted[15:0]};
                wr_mask  = BITS_SIZE'(16'hFFFF) << lane_sh;
            end
            default: begin
                misalign_cond = |i_alu_result[1:0];
                load_val      = rd_word;
                wr_mask       = '1;
            end
        endcase
    end

    // Read-modify-write merge keeps untouched lanes intact.
    assign mem_word_d = (rd_word & ~wr_mask) | ((i_write_data << lane_sh) & wr_mask);
    assign mem_we     = i_mem_write && !misalign_cond && !i_stall && !i_flush;

    always_comb begin
        mem_to_reg_d  = i_mem_to_reg;
        halt_d        = i_halt;
        alu_d         = i_alu_result;
        rd_d          = i_rd;
        misaligned_d  = (i_mem_read || i_mem_write) && misalign_cond;
        reg_write_d   = i_reg_write && !misaligned_d;
        data_to_reg_d = '0;
        if (i_lui) begin
            data_to_reg_d = BITS_SIZE'({i_imm, 16'h0000});
        end else if (i_mem_read && !misalign_cond) begin
            data_to_reg_d = load_val;
        end

        if (i_flush) begin
            mem_to_reg_d  = 1'b0;
            reg_write_d   = 1'b0;
            halt_d        = 1'b0;
            misaligned_d  = 1'b0;
            data_to_reg_d = '0;
            alu_d         = '0;
            rd_d          = '0;
        end else if (i_stall) begin
            mem_to_reg_d  = mem_to_reg_q;
            reg_write_d   = reg_write_q;
            halt_d        = halt_q;
            misaligned_d  = misaligned_q;
            data_to_reg_d = data_to_reg_q;
            alu_d         = alu_q;
            rd_d          = rd_q;
        end
    end

    // Memory has no reset; an asserted reset only gates the write strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && mem_we) begin
            mem_q[widx] <= mem_word_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem_to_reg_q  <= 1'b0;
            reg_write_q   <= 1'b0;
            halt_q        <= 1'b0;
            misaligned_q  <= 1'b0;
            data_to_reg_q <= '0;
            alu_q         <= '0;
            rd_q          <= '0;
        end else begin
            mem_to_reg_q  <= mem_to_reg_d;
            reg_write_q   <= reg_write_d;
            halt_q        <= halt_d;
            misaligned_q  <= misaligned_d;
            data_to_reg_q <= data_to_reg_d;
            alu_q         <= alu_d;
            rd_q          <= rd_d;
        end
    end

    assign o_mem_to_reg  = mem_to_reg_q;
    assign o_reg_write   = reg_write_q;
    assign o_halt        = halt_q;
    assign o_misaligned  = misaligned_q;
    assign o_data_to_reg = data_to_reg_q;
    assign o_alu         = alu_q;
    assign o_rd          = rd_q;

endmodule
